ts_trigger_seq: RTL and testbench

Parametrised arm/trigger sequencer for the trigger subsystem. It runs the idle → initiate → arm → trigger → measure loop with configurable arm and trigger counts. It adds synchronised, edge-selectable external arm/trigger sources, a programmable trigger-to-start delay, RTC timestamp capture per accepted trigger, and missed-trigger detection. It sits between the AXI register bank (ctrl_/stat_ signals) and the measurement engine (measure_* handshake).

---
 rtl/ts_trigger_seq.sv | 249 ++++++++++++++++++++++++
 tb/tb_ts_trigger_seq.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_trigger_seq.sv
// Arm/trigger sequencer: synchronised external events, trigger delay,
// RTC timestamp per accepted trigger and sticky missed-trigger status.
module ts_trigger_seq #(
  parameter int unsigned N_EXT = 8,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned DLY_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      rtc_sec,
  input  logic [31:0]      rtc_nsec,
  input  logic [N_EXT-1:0] ext_trigger,
  output logic             measure_start,
  input  logic             measure_ready,
  input  logic             measure_done,
  input  logic             ctrl_abort,
  input  logic             ctrl_init_immediate,
  input  logic             ctrl_init_continuous,
  input  logic             ctrl_arm_immediate,
  input  logic             ctrl_trigger_immediate,
  input  logic [N_EXT-1:0] ctrl_arm_source,
  input  logic [N_EXT-1:0] ctrl_trigger_source,
  input  logic             ctrl_arm_edge,
  input  logic             ctrl_trigger_edge,
  input  logic [CNT_W-1:0] ctrl_arm_count,
  input  logic [CNT_W-1:0] ctrl_trigger_count,
  input  logic [DLY_W-1:0] ctrl_trigger_delay,
  output logic             stat_operation_complete,
  output logic             stat_sweeping,
  output logic             stat_waiting_for_arm,
  output logic             stat_waiting_for_trigger,
  output logic             stat_measuring,
  output logic             stat_missed_trigger,
  output logic             ts_valid,
  output logic [31:0]      ts_sec,
  output logic [31:0]      ts_nsec,
  output logic [CNT_W-1:0] ts_index
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [DLY_W-1:0] DLY_MAX = '1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_ARM_WAIT,
    S_TRIG_WAIT,
    S_DELAY,
    S_MEAS_START,
    S_MEAS_WAIT,
    S_TRIG_CHECK,
    S_ARM_CHECK
  } state_t;

  state_t state;
  state_t state_next;
  state_t view;

  logic [N_EXT-1:0] sync1;
  logic [N_EXT-1:0] sync2;
  logic [N_EXT-1:0] sync_prev;
  logic [N_EXT-1:0] rise;
  logic [N_EXT-1:0] fall;
  logic             arm_evt;
  logic             trigger_evt;

  logic [CNT_W-1:0] arm_cnt;
  logic [CNT_W-1:0] trig_cnt;
  logic [CNT_W-1:0] arm_cnt_inc;
  logic [CNT_W-1:0] trig_cnt_inc;
  logic [CNT_W-1:0] arm_target;
  logic [CNT_W-1:0] trig_target;
  logic [DLY_W-1:0] dly_cnt;

  logic arm_clr;
  logic arm_inc;
  logic trig_clr;
  logic trig_inc;
  logic dly_clr;
  logic dly_inc;
  logic cnt_zero;
  logic capture;
  logic missed_set;
  logic sweep;

  // Two-flop synchroniser followed by the edge-history register
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
    end else begin
      sync1     <= ext_trigger;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign rise        = sync2 & ~sync_prev;
  assign fall        = ~sync2 & sync_prev;
  assign arm_evt     = ctrl_arm_immediate |
                       (|((ctrl_arm_edge ? fall : rise) & ctrl_arm_source));
  assign trigger_evt = ctrl_trigger_immediate |
                       (|((ctrl_trigger_edge ? fall : rise) & ctrl_trigger_source));

  // Saturating increments and zero-means-one targets
  assign arm_cnt_inc  = (arm_cnt == CNT_MAX) ? arm_cnt : arm_cnt + CNT_W'(1);
  assign trig_cnt_inc = (trig_cnt == CNT_MAX) ? trig_cnt : trig_cnt + CNT_W'(1);
  assign arm_target   = (ctrl_arm_count == '0) ? CNT_W'(1) : ctrl_arm_count;
  assign trig_target  = (ctrl_trigger_count == '0) ? CNT_W'(1) : ctrl_trigger_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    arm_clr    = 1'b0;
    arm_inc    = 1'b0;
    trig_clr   = 1'b0;
    trig_inc   = 1'b0;
    dly_clr    = 1'b0;
    dly_inc    = 1'b0;
    cnt_zero   = 1'b0;
    capture    = 1'b0;
    missed_set = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (ctrl_init_immediate || ctrl_init_continuous) state_next = S_INIT;
      end
      S_INIT: begin
        arm_clr    = 1'b1;
        state_next = S_ARM_WAIT;
      end
      S_ARM_WAIT: begin
        // Arm wins over a coincident trigger, which is then neither taken nor flagged
        if (arm_evt) begin
          trig_clr   = 1'b1;
          state_next = S_TRIG_WAIT;
        end else begin
          missed_set = trigger_evt;
        end
      end
      S_TRIG_WAIT: begin
        if (trigger_evt) begin
          capture    = 1'b1;
          dly_clr    = 1'b1;
          state_next = S_DELAY;
        end
      end
      S_DELAY: begin
        missed_set = trigger_evt;
        if (dly_cnt >= ctrl_trigger_delay) state_next = S_MEAS_START;
        else dly_inc = 1'b1;
      end
      S_MEAS_START: begin
        missed_set = trigger_evt;
        if (measure_ready) state_next = S_MEAS_WAIT;
      end
      S_MEAS_WAIT: begin
        missed_set = trigger_evt;
        if (measure_done) state_next = S_TRIG_CHECK;
      end
      S_TRIG_CHECK: begin
        missed_set = trigger_evt;
        trig_inc   = 1'b1;
        state_next = (trig_cnt_inc >= trig_target) ? S_ARM_CHECK : S_TRIG_WAIT;
      end
      S_ARM_CHECK: begin
        missed_set = trigger_evt;
        arm_inc    = 1'b1;
        if (arm_cnt_inc >= arm_target) begin
          state_next = ctrl_init_continuous ? S_INIT : S_IDLE;
        end else begin
          state_next = S_ARM_WAIT;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (ctrl_abort) begin
      state_next = S_IDLE;
      arm_clr    = 1'b0;
      arm_inc    = 1'b0;
      trig_clr   = 1'b0;
      trig_inc   = 1'b0;
      dly_clr    = 1'b0;
      dly_inc    = 1'b0;
      capture    = 1'b0;
      missed_set = 1'b0;
      cnt_zero   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_zero) begin
      arm_cnt  <= '0;
      trig_cnt <= '0;
      dly_cnt  <= '0;
    end else begin
      if (arm_clr) arm_cnt <= '0;
      else if (arm_inc) arm_cnt <= arm_cnt_inc;
      if (trig_clr) trig_cnt <= '0;
      else if (trig_inc) trig_cnt <= trig_cnt_inc;
      if (dly_clr) dly_cnt <= '0;
      else if (dly_inc && dly_cnt != DLY_MAX) dly_cnt <= dly_cnt + DLY_W'(1);
    end
  end

  // Abort makes the outputs show idle immediately rather than one cycle later
  assign view  = ctrl_abort ? S_IDLE : state;
  assign sweep = view inside {S_ARM_WAIT, S_TRIG_WAIT, S_DELAY, S_MEAS_START,
                              S_MEAS_WAIT, S_TRIG_CHECK, S_ARM_CHECK};

  always_ff @(posedge clk) begin
    if (rst) begin
      measure_start            <= 1'b0;
      stat_operation_complete  <= 1'b0;
      stat_sweeping            <= 1'b0;
      stat_waiting_for_arm     <= 1'b0;
      stat_waiting_for_trigger <= 1'b0;
      stat_measuring           <= 1'b0;
      stat_missed_trigger      <= 1'b0;
      ts_valid                 <= 1'b0;
      ts_sec                   <= '0;
      ts_nsec                  <= '0;
      ts_index                 <= '0;
    end else begin
      measure_start            <= (view == S_MEAS_START);
      stat_operation_complete  <= (view == S_IDLE);
      stat_sweeping            <= sweep;
      stat_waiting_for_arm     <= sweep && (view != S_ARM_CHECK);
      stat_waiting_for_trigger <= (view == S_TRIG_WAIT);
      stat_measuring           <= (view == S_MEAS_START) || (view == S_MEAS_WAIT);
      if (state == S_INIT) stat_missed_trigger <= 1'b0;
      else if (missed_set) stat_missed_trigger <= 1'b1;
      ts_valid <= capture;
      if (capture) begin
        ts_sec   <= rtc_sec;
        ts_nsec  <= rtc_nsec;
        ts_index <= trig_cnt;
      end
    end
  end

endmodule

// File: tb/tb_ts_trigger_seq.sv
// Scoreboard bench for ts_trigger_seq: stimulus pushes expected timestamps,
// a monitor pops them on ts_valid; an engine model answers measure_start.
module tb_ts_trigger_seq;

  localparam int unsigned N_EXT = 8;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned DLY_W = 24;

  logic             clk;
  logic             rst;
  logic [31:0]      rtc_sec;
  logic [31:0]      rtc_nsec;
  logic [N_EXT-1:0] ext_trigger;
  logic             measure_start;
  logic             measure_ready;
  logic             measure_done;
  logic             ctrl_abort;
  logic             ctrl_init_immediate;
  logic             ctrl_init_continuous;
  logic             ctrl_arm_immediate;
  logic             ctrl_trigger_immediate;
  logic [N_EXT-1:0] ctrl_arm_source;
  logic [N_EXT-1:0] ctrl_trigger_source;
  logic             ctrl_arm_edge;
  logic             ctrl_trigger_edge;
  logic [CNT_W-1:0] ctrl_arm_count;
  logic [CNT_W-1:0] ctrl_trigger_count;
  logic [DLY_W-1:0] ctrl_trigger_delay;
  logic             stat_operation_complete;
  logic             stat_sweeping;
  logic             stat_waiting_for_arm;
  logic             stat_waiting_for_trigger;
  logic             stat_measuring;
  logic             stat_missed_trigger;
  logic             ts_valid;
  logic [31:0]      ts_sec;
  logic [31:0]      ts_nsec;
  logic [CNT_W-1:0] ts_index;

  typedef struct {
    logic [CNT_W-1:0] idx;
    logic [31:0]      sec;
    logic [31:0]      nsec;
  } ts_exp_t;

  ts_exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int starts = 0;
  int done_lat = 3;

  ts_trigger_seq #(.N_EXT(N_EXT), .CNT_W(CNT_W), .DLY_W(DLY_W)) dut (
    .clk(clk), .rst(rst), .rtc_sec(rtc_sec), .rtc_nsec(rtc_nsec),
    .ext_trigger(ext_trigger), .measure_start(measure_start),
    .measure_ready(measure_ready), .measure_done(measure_done),
    .ctrl_abort(ctrl_abort), .ctrl_init_immediate(ctrl_init_immediate),
    .ctrl_init_continuous(ctrl_init_continuous),
    .ctrl_arm_immediate(ctrl_arm_immediate),
    .ctrl_trigger_immediate(ctrl_trigger_immediate),
    .ctrl_arm_source(ctrl_arm_source), .ctrl_trigger_source(ctrl_trigger_source),
    .ctrl_arm_edge(ctrl_arm_edge), .ctrl_trigger_edge(ctrl_trigger_edge),
    .ctrl_arm_count(ctrl_arm_count), .ctrl_trigger_count(ctrl_trigger_count),
    .ctrl_trigger_delay(ctrl_trigger_delay),
    .stat_operation_complete(stat_operation_complete),
    .stat_sweeping(stat_sweeping), .stat_waiting_for_arm(stat_waiting_for_arm),
    .stat_waiting_for_trigger(stat_waiting_for_trigger),
    .stat_measuring(stat_measuring), .stat_missed_trigger(stat_missed_trigger),
    .ts_valid(ts_valid), .ts_sec(ts_sec), .ts_nsec(ts_nsec), .ts_index(ts_index)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running RTC, changes just after each rising edge
  initial begin
    rtc_sec  = 32'd100;
    rtc_nsec = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      rtc_nsec = rtc_nsec + 32'd37;
      if (rtc_nsec[3:0] == 4'd0) rtc_sec = rtc_sec + 32'd1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Measurement engine: accepts each start, finishes done_lat cycles later
  initial begin
    logic ms_prev;
    int   timer;
    measure_ready = 1'b0;
    measure_done  = 1'b0;
    ms_prev       = 1'b0;
    timer         = 0;
    forever begin
      @(negedge clk);
      measure_ready = 1'b0;
      measure_done  = 1'b0;
      if (timer > 0) begin
        timer--;
        if (timer == 0) measure_done = 1'b1;
      end
      if (measure_start && !ms_prev) begin
        starts++;
        measure_ready = 1'b1;
        timer = done_lat + 1;
      end
      ms_prev = measure_start;
    end
  end

  // Scoreboard monitor
  initial begin
    logic    ts_prev;
    ts_exp_t e;
    ts_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ts_valid) begin
        chk("ts_single_pulse", 64'(ts_prev), 64'd0);
        chk("ts_expected_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("ts_index", 64'(ts_index), 64'(e.idx));
          chk("ts_sec", 64'(ts_sec), 64'(e.sec));
          chk("ts_nsec", 64'(ts_nsec), 64'(e.nsec));
        end
      end
      ts_prev = ts_valid;
    end
  end

  task automatic push_exp(input int idx);
    ts_exp_t e;
    e.idx  = CNT_W'(idx);
    e.sec  = rtc_sec;
    e.nsec = rtc_nsec;
    exp_q.push_back(e);
  endtask

  task automatic fire_trig(input int idx);
    push_exp(idx);
    ctrl_trigger_immediate = 1'b1;
    @(negedge clk);
    ctrl_trigger_immediate = 1'b0;
  endtask

  task automatic pulse_init();
    ctrl_init_immediate = 1'b1;
    @(negedge clk);
    ctrl_init_immediate = 1'b0;
  endtask

  task automatic wait_trig();
    for (int k = 0; k < 300 && !stat_waiting_for_trigger; k++) @(negedge clk);
    chk("wait_for_trigger_state", 64'(stat_waiting_for_trigger), 64'd1);
  endtask

  task automatic wait_trig_low();
    for (int k = 0; k < 50 && stat_waiting_for_trigger; k++) @(negedge clk);
    chk("trigger_taken", 64'(stat_waiting_for_trigger), 64'd0);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2000 && !stat_operation_complete; k++) @(negedge clk);
    chk("reach_idle", 64'(stat_operation_complete), 64'd1);
  endtask

  task automatic wait_meas_wait();
    for (int k = 0; k < 200 && !(stat_measuring && !measure_start); k++) @(negedge clk);
    chk("reach_meas_wait", 64'(stat_measuring && !measure_start), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_measure_start"}, 64'(measure_start), 64'd0);
    chk({tag, "_op_complete"}, 64'(stat_operation_complete), 64'd0);
    chk({tag, "_sweeping"}, 64'(stat_sweeping), 64'd0);
    chk({tag, "_wait_arm"}, 64'(stat_waiting_for_arm), 64'd0);
    chk({tag, "_wait_trig"}, 64'(stat_waiting_for_trigger), 64'd0);
    chk({tag, "_measuring"}, 64'(stat_measuring), 64'd0);
    chk({tag, "_missed"}, 64'(stat_missed_trigger), 64'd0);
    chk({tag, "_ts_valid"}, 64'(ts_valid), 64'd0);
    chk({tag, "_ts_sec"}, 64'(ts_sec), 64'd0);
    chk({tag, "_ts_nsec"}, 64'(ts_nsec), 64'd0);
    chk({tag, "_ts_index"}, 64'(ts_index), 64'd0);
  endtask

  // One full sequence driven by software trigger pulses
  task automatic run_seq(input int na, input int nt, input int dly);
    int ea;
    int et;
    int s0;
    ea = (na == 0) ? 1 : na;
    et = (nt == 0) ? 1 : nt;
    ctrl_arm_count     = CNT_W'(na);
    ctrl_trigger_count = CNT_W'(nt);
    ctrl_trigger_delay = DLY_W'(dly);
    s0 = starts;
    pulse_init();
    for (int a = 0; a < ea; a++) begin
      for (int t = 0; t < et; t++) begin
        wait_trig();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        fire_trig(t);
        wait_trig_low();
      end
    end
    wait_idle();
    chk("seq_measure_count", 64'(starts - s0), 64'(ea * et));
    chk("seq_no_missed", 64'(stat_missed_trigger), 64'd0);
    chk("seq_ts_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int s0;
    int lat;
    rst = 1'b1;
    ext_trigger = '0;
    ctrl_abort = 1'b0;
    ctrl_init_immediate = 1'b0;
    ctrl_init_continuous = 1'b0;
    ctrl_arm_immediate = 1'b0;
    ctrl_trigger_immediate = 1'b0;
    ctrl_arm_source = '0;
    ctrl_trigger_source = '0;
    ctrl_arm_edge = 1'b0;
    ctrl_trigger_edge = 1'b0;
    ctrl_arm_count = '0;
    ctrl_trigger_count = '0;
    ctrl_trigger_delay = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 64'(stat_operation_complete), 64'd1);

    // Arm held permanently: each arm wait lasts one cycle, never flagged
    ctrl_arm_immediate = 1'b1;
    run_seq(2, 3, 1);
    run_seq(0, 0, 0);
    for (int it = 0; it < 4; it++) begin
      done_lat = $urandom_range(0, 5);
      run_seq($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
    end
    done_lat = 3;

    // External line 3: falling edge ignored, rising edge accepted with delay 10
    ctrl_arm_count = CNT_W'(1);
    ctrl_trigger_count = CNT_W'(1);
    ctrl_trigger_delay = DLY_W'(10);
    ctrl_trigger_edge = 1'b0;
    ctrl_trigger_source = '0;
    s0 = starts;
    pulse_init();
    wait_trig();
    ext_trigger[3] = 1'b1;
    repeat (5) @(negedge clk);
    ctrl_trigger_source = 8'h08;
    repeat (2) @(negedge clk);
    ext_trigger[3] = 1'b0;
    repeat (8) @(negedge clk);
    chk("falling_ignored_wait", 64'(stat_waiting_for_trigger), 64'd1);
    chk("falling_ignored_starts", 64'(starts - s0), 64'd0);
    ext_trigger[3] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 2) push_exp(0);
      if (measure_start) begin
        lat = k;
        break;
      end
    end
    chk("ext_edge_to_start", 64'(lat), 64'd15);
    wait_idle();
    chk("ext_measure_count", 64'(starts - s0), 64'd1);
    ctrl_trigger_source = '0;
    ext_trigger[3] = 1'b0;
    repeat (4) @(negedge clk);

    // Trigger during measurement is flagged and not measured
    ctrl_trigger_count = CNT_W'(2);
    ctrl_trigger_delay = DLY_W'(0);
    done_lat = 20;
    s0 = starts;
    pulse_init();
    wait_trig();
    fire_trig(0);
    wait_meas_wait();
    ctrl_trigger_immediate = 1'b1;
    @(negedge clk);
    ctrl_trigger_immediate = 1'b0;
    @(negedge clk);
    chk("missed_set", 64'(stat_missed_trigger), 64'd1);
    chk("missed_still_measuring", 64'(stat_measuring), 64'd1);
    wait_trig();
    fire_trig(1);
    wait_idle();
    chk("missed_measure_count", 64'(starts - s0), 64'd2);
    chk("missed_sticky", 64'(stat_missed_trigger), 64'd1);
    pulse_init();
    @(negedge clk);
    chk("missed_cleared_by_init", 64'(stat_missed_trigger), 64'd0);
    for (int t = 0; t < 2; t++) begin
      wait_trig();
      fire_trig(t);
      wait_trig_low();
    end
    wait_idle();
    chk("missed_ts_drained", 64'(exp_q.size()), 64'd0);

    // Continuous mode then abort during measurement wait
    ctrl_init_continuous = 1'b1;
    done_lat = 30;
    s0 = starts;
    for (int t = 0; t < 2; t++) begin
      wait_trig();
      fire_trig(t);
      wait_trig_low();
    end
    wait_trig();
    fire_trig(0);
    wait_meas_wait();
    ctrl_abort = 1'b1;
    ctrl_init_continuous = 1'b0;
    @(negedge clk);
    ctrl_abort = 1'b0;
    chk("abort_idle", 64'(stat_operation_complete), 64'd1);
    chk("abort_measure_start", 64'(measure_start), 64'd0);
    chk("abort_sweeping", 64'(stat_sweeping), 64'd0);
    chk("abort_measuring", 64'(stat_measuring), 64'd0);
    repeat (40) @(negedge clk);
    chk("abort_stays_idle", 64'(stat_operation_complete), 64'd1);
    chk("abort_measure_count", 64'(starts - s0), 64'd3);
    done_lat = 2;
    run_seq(1, 2, 1);

    // Reset during a long delay abandons the pending measurement
    ctrl_arm_count = CNT_W'(1);
    ctrl_trigger_count = CNT_W'(1);
    ctrl_trigger_delay = DLY_W'(1000);
    s0 = starts;
    pulse_init();
    wait_trig();
    fire_trig(0);
    repeat (6) @(negedge clk);
    chk("reset_in_delay_sweeping", 64'(stat_sweeping), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;
    repeat (1100) @(negedge clk);
    chk("reset_no_start", 64'(starts - s0), 64'd0);
    chk("reset_idle", 64'(stat_operation_complete), 64'd1);
    chk("final_ts_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
